// File: rtl/fetch_pkg.sv
// Shared constants and types for the instruction-fetch stage.
package fetch_pkg;

   localparam int unsigned ADDR_W  = 8;
   localparam int unsigned INSTR_W = 17;

   localparam logic [ADDR_W-1:0]  RESET_PC  = 8'h00;
   localparam logic [INSTR_W-1:0] NOP_INSTR = 17'b0;

   typedef enum logic {
      IDLE  = 1'b0,
      FETCH = 1'b1
   } fetch_state_t;

endpackage

// File: rtl/fetch_unit.sv
// Instruction fetch: owns the PC, drives prog_mem, and holds a one-entry IR
// handed to decode over valid/ready, with start/halt and branch redirect.
module fetch_unit
   import fetch_pkg::*;
(
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic               halt,
   input  logic               redirect_valid,
   input  logic [ADDR_W-1:0]  redirect_addr,
   output logic [ADDR_W-1:0]  mem_addr,
   output logic               mem_cs,
   input  logic [INSTR_W-1:0] mem_instr,
   output logic               ir_valid,
   input  logic               ir_ready,
   output logic [INSTR_W-1:0] ir_instr,
   output logic [ADDR_W-1:0]  ir_pc,
   output logic               busy
);

   fetch_state_t       state_q, state_d;
   logic [ADDR_W-1:0]  pc_q, pc_d;
   logic [INSTR_W-1:0] ir_instr_q, ir_instr_d;
   logic [ADDR_W-1:0]  ir_pc_q, ir_pc_d;
   logic               ir_valid_q, ir_valid_d;
   logic               ld;

   // State, PC and IR registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= IDLE;
         pc_q       <= RESET_PC;
         ir_instr_q <= NOP_INSTR;
         ir_pc_q    <= '0;
         ir_valid_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         pc_q       <= pc_d;
         ir_instr_q <= ir_instr_d;
         ir_pc_q    <= ir_pc_d;
         ir_valid_q <= ir_valid_d;
      end
   end

   // Next state, load decision and IR/PC update; redirect overrides everything
   always_comb begin
      state_d    = state_q;
      pc_d       = pc_q;
      ir_instr_d = ir_instr_q;
      ir_pc_d    = ir_pc_q;
      ir_valid_d = ir_valid_q;
      ld         = 1'b0;

      unique case (state_q)
         IDLE:    if (start && !halt && !redirect_valid) state_d = FETCH;
         FETCH:   if (halt) state_d = IDLE;
         default: state_d = IDLE;
      endcase

      // A halt edge only drains; it never fetches.
      ld = (state_q == FETCH) && !halt && !redirect_valid
           && (!ir_valid_q || ir_ready);

      if (redirect_valid) begin
         pc_d       = redirect_addr;
         ir_valid_d = 1'b0;
      end else if (ld) begin
         ir_instr_d = mem_instr;
         ir_pc_d    = pc_q;
         ir_valid_d = 1'b1;
         pc_d       = pc_q + ADDR_W'(1);
      end else if (ir_valid_q && ir_ready) begin
         ir_valid_d = 1'b0;
      end
   end

   assign mem_addr = pc_q;
   assign mem_cs   = (state_q == FETCH);
   assign busy     = (state_q == FETCH);
   assign ir_valid = ir_valid_q;
   assign ir_instr = ir_instr_q;
   assign ir_pc    = ir_pc_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with a combinational program-memory model.
module tb_fetch_unit;
   import fetch_pkg::*;

   logic               clk = 1'b0;
   logic               rst;
   logic               start, halt, redirect_valid, ir_ready;
   logic [ADDR_W-1:0]  redirect_addr;
   logic [ADDR_W-1:0]  mem_addr;
   logic               mem_cs, ir_valid, busy;
   logic [INSTR_W-1:0] mem_instr, ir_instr;
   logic [ADDR_W-1:0]  ir_pc;

   logic [INSTR_W-1:0] rom [256];

   int checks = 0;
   int passed = 0;

   always #5 clk = ~clk;

   assign mem_instr = rom[mem_addr];

   fetch_unit dut (
      .clk(clk), .rst(rst), .start(start), .halt(halt),
      .redirect_valid(redirect_valid), .redirect_addr(redirect_addr),
      .mem_addr(mem_addr), .mem_cs(mem_cs), .mem_instr(mem_instr),
      .ir_valid(ir_valid), .ir_ready(ir_ready), .ir_instr(ir_instr),
      .ir_pc(ir_pc), .busy(busy)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: got %h expected %h", tag, obs, exp);
   endtask

   // Advance through one rising edge; sample at the following falling edge.
   task automatic tick();
      @(negedge clk);
   endtask

   initial begin
      for (int i = 0; i < 256; i++) rom[i] = 17'(i * 7 + 17'h10000);
      rom[8'h01] = 17'h08004;
      rom[8'h02] = 17'h04008;
      rom[8'h10] = 17'h00068;

      rst = 1'b1; start = 1'b0; halt = 1'b0; redirect_valid = 1'b0;
      redirect_addr = '0; ir_ready = 1'b1;
      #12;
      chk("rst_mem_addr", 32'(mem_addr), 32'h00);
      chk("rst_mem_cs",   32'(mem_cs),   32'h0);
      chk("rst_ir_valid", 32'(ir_valid), 32'h0);
      chk("rst_ir_instr", 32'(ir_instr), 32'h0);
      chk("rst_ir_pc",    32'(ir_pc),    32'h0);
      chk("rst_busy",     32'(busy),     32'h0);
      @(negedge clk); rst = 1'b0;

      // Start pulse
      start = 1'b1; tick(); start = 1'b0;
      chk("start_busy",     32'(busy),     32'h1);
      chk("start_cs",       32'(mem_cs),   32'h1);
      chk("start_addr",     32'(mem_addr), 32'h00);
      chk("start_irv",      32'(ir_valid), 32'h0);
      ir_ready = 1'b0; tick();
      chk("first_valid",    32'(ir_valid), 32'h1);
      chk("first_pc",       32'(ir_pc),    32'h00);
      chk("first_instr",    32'(ir_instr), 32'h10000);

      // Stall three cycles with IR full
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("stall_pc",    32'(ir_pc),    32'h00);
         chk("stall_instr", 32'(ir_instr), 32'h10000);
         chk("stall_addr",  32'(mem_addr), 32'h01);
         chk("stall_cs",    32'(mem_cs),   32'h1);
      end
      ir_ready = 1'b1; tick();
      chk("rel_pc01",    32'(ir_pc),    32'h01);
      chk("rel_instr01", 32'(ir_instr), 32'h08004);
      tick();
      chk("pc02",        32'(ir_pc),    32'h02);
      chk("instr02",     32'(ir_instr), 32'h04008);
      tick(); tick(); tick();
      chk("pc05",        32'(ir_pc),    32'h05);
      chk("addr06",      32'(mem_addr), 32'h06);

      // Redirect to 0x10
      redirect_valid = 1'b1; redirect_addr = 8'h10; tick();
      redirect_valid = 1'b0;
      chk("redir_flush", 32'(ir_valid), 32'h0);
      chk("redir_addr",  32'(mem_addr), 32'h10);
      tick();
      chk("redir_valid", 32'(ir_valid), 32'h1);
      chk("redir_pc",    32'(ir_pc),    32'h10);
      chk("redir_instr", 32'(ir_instr), 32'h00068);

      // PC wrap
      redirect_valid = 1'b1; redirect_addr = 8'hFE; tick();
      redirect_valid = 1'b0;
      chk("wrap_addr",   32'(mem_addr), 32'hFE);
      tick();
      chk("wrap_pcFE",   32'(ir_pc),    32'hFE);
      tick();
      chk("wrap_pcFF",   32'(ir_pc),    32'hFF);
      chk("wrap_instrFF",32'(ir_instr), 32'(17'(255 * 7 + 17'h10000)));
      tick();
      chk("wrap_pc00",   32'(ir_pc),    32'h00);
      chk("wrap_valid",  32'(ir_valid), 32'h1);
      chk("wrap_addr01", 32'(mem_addr), 32'h01);

      // Halt with IR full and decode stalled
      ir_ready = 1'b0; halt = 1'b1; tick(); halt = 1'b0;
      chk("halt_busy",   32'(busy),     32'h0);
      chk("halt_cs",     32'(mem_cs),   32'h0);
      chk("halt_irv",    32'(ir_valid), 32'h1);
      chk("halt_pc",     32'(ir_pc),    32'h00);
      chk("halt_addr",   32'(mem_addr), 32'h01);
      ir_ready = 1'b1; tick();
      chk("drain_irv",   32'(ir_valid), 32'h0);
      chk("drain_addr",  32'(mem_addr), 32'h01);
      start = 1'b1; tick(); start = 1'b0;
      chk("resume_busy", 32'(busy),     32'h1);
      chk("resume_addr", 32'(mem_addr), 32'h01);
      tick();
      chk("resume_pc",   32'(ir_pc),    32'h01);
      chk("resume_instr",32'(ir_instr), 32'h08004);

      // Asynchronous reset mid-stream
      #2 rst = 1'b1; #1;
      chk("arst_busy",   32'(busy),     32'h0);
      chk("arst_addr",   32'(mem_addr), 32'h00);
      chk("arst_irv",    32'(ir_valid), 32'h0);
      chk("arst_instr",  32'(ir_instr), 32'h0);
      chk("arst_pc",     32'(ir_pc),    32'h0);
      @(negedge clk); rst = 1'b0;

      // start and halt together in IDLE
      start = 1'b1; halt = 1'b1; tick(); start = 1'b0; halt = 1'b0;
      chk("sh_busy",     32'(busy),     32'h0);
      chk("sh_cs",       32'(mem_cs),   32'h0);
      chk("sh_addr",     32'(mem_addr), 32'h00);

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
